player_motion: RTL and testbench

- Downstream of the key input decoder; consumes its 3-bit `movement` command stream and produces the runner's vertical state for the renderer and the collision logic.
- Integrates a jump trajectory once per video frame: position += velocity, velocity -= gravity.
- Handles crouch and fast-drop, and reports landing.

---
 rtl/running_man_pkg.sv | 23 ++
 rtl/player_motion.sv | 115 +++++++++++
 tb/tb_player_motion.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/running_man_pkg.sv
// Shared definitions for the running-man player path: movement command codes
// from the key decoder, the vertical motion state and the pending-command latch.
package running_man_pkg;

  localparam logic [2:0] MV_NONE       = 3'b000;
  localparam logic [2:0] MV_BIG_JUMP   = 3'b001;
  localparam logic [2:0] MV_SMALL_JUMP = 3'b010;
  localparam logic [2:0] MV_CROUCH     = 3'b011;
  localparam logic [2:0] MV_DROP       = 3'b100;

  typedef enum logic {
    GROUND = 1'b0,
    AIR    = 1'b1
  } motion_state_t;

  typedef enum logic [1:0] {
    PEND_NONE  = 2'd0,
    PEND_BIG   = 2'd1,
    PEND_SMALL = 2'd2,
    PEND_DROP  = 2'd3
  } pend_t;

endpackage

// File: rtl/player_motion.sv
// Vertical motion of the runner: latches jump/drop commands between frames and
// integrates height/velocity once per frame_tick, reporting crouch and landing.
//
// state  | meaning
// GROUND | player_y == 0, waiting for a jump command
// AIR    | trajectory integrated every frame until height reaches 0
module player_motion
  import running_man_pkg::*;
#(
  parameter int Y_W      = 7,
  parameter int V_W      = 6,
  parameter int Y_MAX    = 127,
  parameter int BIG_V0   = 12,
  parameter int SMALL_V0 = 8,
  parameter int GRAVITY  = 1,
  parameter int DROP_V   = 10,
  parameter int MAX_FALL = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic [2:0]     movement,
  output logic [Y_W-1:0] player_y,
  output logic           airborne,
  output logic           crouch,
  output logic           landed
);

  localparam logic signed [V_W-1:0] DROP_NEG = V_W'(-DROP_V);
  localparam logic signed [V_W:0]   GRAV_W   = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   FLOOR_W  = (V_W+1)'(-MAX_FALL);
  localparam logic signed [Y_W+1:0] YMAX_W   = (Y_W+2)'(Y_MAX);

  motion_state_t         state;
  pend_t                 pending;
  pend_t                 cmd_code;
  pend_t                 eff;
  logic signed [V_W-1:0] vel;
  logic signed [V_W-1:0] v_air;
  logic signed [V_W:0]   v_dec;
  logic signed [V_W-1:0] vel_next;
  logic signed [Y_W+1:0] s;

  always_comb begin
    cmd_code = PEND_NONE;
    case (movement)
      MV_BIG_JUMP:   cmd_code = PEND_BIG;
      MV_SMALL_JUMP: cmd_code = PEND_SMALL;
      MV_DROP:       cmd_code = PEND_DROP;
      default:       cmd_code = PEND_NONE;
    endcase
  end

  // A command arriving with the tick is used directly rather than latched.
  assign eff = (cmd_code != PEND_NONE) ? cmd_code : pending;

  always_comb begin
    v_air = vel;
    if (eff == PEND_DROP && vel > DROP_NEG) v_air = DROP_NEG;
    s     = $signed({2'b00, player_y}) + $signed({{(Y_W+2-V_W){v_air[V_W-1]}}, v_air});
    v_dec = $signed({v_air[V_W-1], v_air}) - GRAV_W;
    vel_next = (v_dec < FLOOR_W) ? FLOOR_W[V_W-1:0] : v_dec[V_W-1:0];
  end

  assign airborne = (state == AIR);

  always_ff @(posedge clk) begin
    if (reset) begin
      player_y <= '0;
      vel      <= '0;
      state    <= GROUND;
      pending  <= PEND_NONE;
      crouch   <= 1'b0;
      landed   <= 1'b0;
    end else begin
      crouch <= (state == GROUND) && (movement == MV_CROUCH);
      landed <= 1'b0;
      if (frame_tick) begin
        pending <= PEND_NONE;
        case (state)
          GROUND: begin
            if (eff == PEND_BIG) begin
              player_y <= Y_W'(BIG_V0);
              vel      <= V_W'(BIG_V0 - GRAVITY);
              state    <= AIR;
            end else if (eff == PEND_SMALL) begin
              player_y <= Y_W'(SMALL_V0);
              vel      <= V_W'(SMALL_V0 - GRAVITY);
              state    <= AIR;
            end
          end
          AIR: begin
            if (s[Y_W+1] || s == '0) begin
              player_y <= '0;
              vel      <= '0;
              state    <= GROUND;
              landed   <= 1'b1;
            end else if (s > YMAX_W) begin
              // Ceiling bump: hold at the top, the fall begins on the next frame.
              player_y <= Y_W'(Y_MAX);
              vel      <= '0;
            end else begin
              player_y <= s[Y_W-1:0];
              vel      <= vel_next;
            end
          end
          default: state <= GROUND;
        endcase
      end else if (cmd_code != PEND_NONE) begin
        pending <= cmd_code;
      end
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: stimulus pushes hand-computed expected
// outputs, a monitor pops and compares after every tick/reset/probe edge.
module tb_player_motion;
  import running_man_pkg::*;

  typedef struct packed {
    logic [6:0] y;
    logic       air;
    logic       land;
    logic       cr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] movement = MV_NONE;
  logic [6:0] player_y;
  logic       airborne;
  logic       crouch;
  logic       landed;

  logic chk = 1'b0;
  logic obs = 1'b0;
  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  player_motion dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .movement   (movement),
    .player_y   (player_y),
    .airborne   (airborne),
    .crouch     (crouch),
    .landed     (landed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) obs <= frame_tick | chk | reset;

  always @(negedge clk) begin
    if (obs) begin
      exp_t  e;
      string nm;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got y=%0d air=%0b land=%0b cr=%0b, nothing expected",
                 player_y, airborne, landed, crouch);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (player_y !== e.y || airborne !== e.air || landed !== e.land || crouch !== e.cr) begin
          fails++;
          $display("FAIL %s: got y=%0d air=%0b land=%0b cr=%0b, expected y=%0d air=%0b land=%0b cr=%0b",
                   nm, player_y, airborne, landed, crouch, e.y, e.air, e.land, e.cr);
        end
      end
    end
  end

  task automatic step(input logic [2:0] mv, input logic tk, input logic ck, input logic rs,
                      input logic [6:0] y, input logic air, input logic land, input logic cr,
                      input string nm);
    exp_t e;
    @(negedge clk);
    movement   = mv;
    frame_tick = tk;
    chk        = ck;
    reset      = rs;
    if (tk || ck || rs) begin
      e.y = y; e.air = air; e.land = land; e.cr = cr;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic idle(input logic [2:0] mv);
    step(mv, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, "");
  endtask

  task automatic do_reset(input string nm);
    step(MV_NONE, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic tick(input logic [2:0] mv, input logic [6:0] y, input logic air,
                      input logic land, input logic cr, input string nm);
    step(mv, 1'b1, 1'b0, 1'b0, y, air, land, cr, nm);
  endtask

  task automatic probe(input logic [2:0] mv, input logic [6:0] y, input logic air,
                       input logic cr, input string nm);
    step(mv, 1'b0, 1'b1, 1'b0, y, air, 1'b0, cr, nm);
  endtask

  logic [6:0] big_y[25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                            77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
  logic [6:0] small_y[17] = '{8, 15, 21, 26, 30, 33, 35, 36, 36,
                              35, 33, 30, 26, 21, 15, 8, 0};
  logic [6:0] drop_y[5] = '{40, 29, 17, 4, 0};

  initial begin
    do_reset("reset_state");
    idle(MV_NONE);
    tick(MV_NONE, 7'd0, 1'b0, 1'b0, 1'b0, "idle_tick_no_jump");

    // big jump full arc
    idle(MV_BIG_JUMP);
    idle(MV_NONE);
    for (int i = 0; i < 25; i++)
      tick(MV_NONE, big_y[i], (i < 24), (i == 24), 1'b0, "big_jump");
    probe(MV_NONE, 7'd0, 1'b0, 1'b0, "land_pulse_ends");

    // small jump full arc
    idle(MV_SMALL_JUMP);
    for (int i = 0; i < 17; i++)
      tick(MV_NONE, small_y[i], (i < 16), (i == 16), 1'b0, "small_jump");

    // drop mid-air after tick 5
    idle(MV_BIG_JUMP);
    for (int i = 0; i < 5; i++)
      tick(MV_NONE, big_y[i], 1'b1, 1'b0, 1'b0, "drop_prefix");
    idle(MV_DROP);
    idle(MV_NONE);
    for (int i = 0; i < 5; i++)
      tick(MV_NONE, drop_y[i], (i < 4), (i == 4), 1'b0, "drop_fall");

    // latest command wins
    idle(MV_BIG_JUMP);
    idle(MV_SMALL_JUMP);
    tick(MV_NONE, 7'd8, 1'b1, 1'b0, 1'b0, "latest_cmd_small");
    do_reset("reset_after_small");

    // command coincident with tick is consumed, then jump in air ignored
    tick(MV_BIG_JUMP, 7'd12, 1'b1, 1'b0, 1'b0, "same_cycle_cmd");
    tick(MV_NONE, 7'd23, 1'b1, 1'b0, 1'b0, "same_cycle_next");
    idle(MV_BIG_JUMP);
    tick(MV_NONE, 7'd33, 1'b1, 1'b0, 1'b0, "air_jump_ignored");
    tick(MV_BIG_JUMP, 7'd42, 1'b1, 1'b0, 1'b0, "air_jump_tick_ignored");
    do_reset("reset_after_air_jump");

    // crouch on ground and release
    idle(MV_CROUCH);
    probe(MV_CROUCH, 7'd0, 1'b0, 1'b1, "crouch_held");
    probe(MV_NONE, 7'd0, 1'b0, 1'b0, "crouch_released");

    // crouch while airborne stays low
    tick(MV_BIG_JUMP, 7'd12, 1'b1, 1'b0, 1'b0, "air_launch");
    idle(MV_CROUCH);
    probe(MV_CROUCH, 7'd12, 1'b1, 1'b0, "crouch_in_air");
    do_reset("reset_after_air_crouch");

    // pending jump survives crouch, crouch drops after launch
    idle(MV_BIG_JUMP);
    idle(MV_CROUCH);
    probe(MV_CROUCH, 7'd0, 1'b0, 1'b1, "crouch_with_pending");
    tick(MV_CROUCH, 7'd12, 1'b1, 1'b0, 1'b1, "jump_while_crouch");
    probe(MV_CROUCH, 7'd12, 1'b1, 1'b0, "crouch_drops_after_jump");
    do_reset("reset_after_crouch_jump");

    // reset mid-jump with a pending command
    idle(MV_BIG_JUMP);
    for (int i = 0; i < 5; i++)
      tick(MV_NONE, big_y[i], 1'b1, 1'b0, 1'b0, "pre_reset_jump");
    idle(MV_BIG_JUMP);
    do_reset("reset_mid_jump");
    idle(MV_NONE);
    tick(MV_NONE, 7'd0, 1'b0, 1'b0, 1'b0, "no_jump_after_reset");

    idle(MV_NONE);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected responses never observed, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
